key_led_port: RTL and testbench

- Memory-mapped I/O peripheral on the N6502 core bus, between the core and the board pins.
- Upstream of the core: supplies read data from 4 debounced keys and a press-edge latch.
- Downstream of the core: latches core write data into an 8-bit LED register.
- Top level muxes `io_data` into the core input whenever `io_hit` is set.

---
 rtl/key_led_port_if.sv | 30 +++
 rtl/key_led_port.sv | 114 +++++++++++
 tb/tb_key_led_port.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/key_led_port_if.sv
// Core-bus side of the key/LED peripheral.
//   address : core bus address
//   out     : core write data
//   we      : core write strobe, active high
//   io_data : registered read data returned to the core
//   io_hit  : registered; io_data is valid for the previous cycle's address
// master = N6502 core side, slave = peripheral side.
interface key_led_port_if;
  logic [15:0] address;
  logic [7:0]  out;
  logic        we;
  logic [7:0]  io_data;
  logic        io_hit;

  modport master (
    output address,
    output out,
    output we,
    input  io_data,
    input  io_hit
  );

  modport slave (
    input  address,
    input  out,
    input  we,
    output io_data,
    output io_hit
  );
endinterface

// File: rtl/key_led_port.sv
// Memory-mapped key/LED peripheral for the N6502 core bus.
// Register map, offsets from BASE:
//   +0 LED  read/write 8-bit LED register
//   +1 KEY  read-only {4'b0, stable}, 1 = pressed
//   +2 EDGE read {4'b0, press latch}; write 1 to clear bits [3:0]
//   +3 ID   read-only ID_VALUE
// Ports:
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   bus     : core bus (address, out, we, io_data, io_hit), slave side
//   key     : raw asynchronous key pins
//   led     : LED register contents
// Reads have one cycle of latency; io_data is 0 whenever io_hit is 0.
module key_led_port #(
  parameter logic [15:0] BASE            = 16'hC000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1,
  parameter logic [7:0]  ID_VALUE        = 8'h65
) (
  input  logic                 clock,
  input  logic                 reset_n,
  key_led_port_if.slave        bus,
  input  logic [3:0]           key,
  output logic [7:0]           led
);

  localparam int unsigned CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]   RELEASED = {4{KEY_ACTIVE_LOW}};

  logic [3:0]    sync1, sync2;
  logic [3:0]    sample;
  logic [3:0]    stable, stable_nxt;
  logic [CW-1:0] cnt     [4];
  logic [CW-1:0] cnt_nxt [4];
  logic [3:0]    rise;
  logic [3:0]    edge_lat, edge_nxt;
  logic [3:0]    clr;

  logic [15:0]   offs;
  logic          hit;
  logic          wr_led;
  logic [7:0]    rdata;

  // Offset relative to BASE; a hit is any offset 0..3.
  assign offs = bus.address - BASE;
  assign hit  = (offs[15:2] == '0);

  assign sample = KEY_ACTIVE_LOW ? ~sync2 : sync2;

  always_comb begin
    stable_nxt = stable;
    rise       = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_nxt[i] = cnt[i];
      if (sample[i] == stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        stable_nxt[i] = sample[i];
        cnt_nxt[i]    = '0;
        rise[i]       = sample[i];
      end else begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  // Clear and press latch resolved together so a same-cycle press survives the clear.
  always_comb begin
    wr_led   = bus.we && hit && (offs[1:0] == 2'd0);
    clr      = (bus.we && hit && (offs[1:0] == 2'd2)) ? bus.out[3:0] : '0;
    edge_nxt = (edge_lat & ~clr) | rise;
  end

  always_comb begin
    rdata = '0;
    unique case (offs[1:0])
      2'd0: rdata = led;
      2'd1: rdata = {4'b0000, stable};
      2'd2: rdata = {4'b0000, edge_lat};
      2'd3: rdata = ID_VALUE;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= RELEASED;
      sync2    <= RELEASED;
      stable   <= '0;
      edge_lat <= '0;
      led      <= '0;
      bus.io_data <= '0;
      bus.io_hit  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1    <= key;
      sync2    <= sync1;
      stable   <= stable_nxt;
      edge_lat <= edge_nxt;
      if (wr_led) begin
        led <= bus.out;
      end
      bus.io_hit  <= hit;
      bus.io_data <= hit ? rdata : '0;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_key_led_port.sv
module tb_key_led_port;

  logic       clock;
  logic       reset_n;
  logic [3:0] key;
  logic [7:0] led;

  int checks;
  int failures;

  key_led_port_if bus ();

  key_led_port #(
    .BASE            (16'hC000),
    .DEBOUNCE_CYCLES (4),
    .KEY_ACTIVE_LOW  (1'b1),
    .ID_VALUE        (8'h65)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .key     (key),
    .led     (led)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, input string tag, input logic [7:0] exp);
    bus.address = a;
    bus.we      = 1'b0;
    tick();
    check({tag, "_hit"}, {7'b0, bus.io_hit}, 8'h01);
    check(tag, bus.io_data, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.address = a;
    bus.out     = d;
    bus.we      = 1'b1;
    tick();
    bus.we      = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b0;
    key         = 4'hF;
    bus.address = 16'h0000;
    bus.out     = 8'h00;
    bus.we      = 1'b0;

    #12;
    check("rst_led", led, 8'h00);
    check("rst_hit", {7'b0, bus.io_hit}, 8'h00);
    check("rst_data", bus.io_data, 8'h00);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // ID and miss
    rd(16'hC003, "id", 8'h65);
    check("led_init", led, 8'h00);
    bus.address = 16'h0000;
    tick();
    check("miss_hit", {7'b0, bus.io_hit}, 8'h00);
    check("miss_data", bus.io_data, 8'h00);

    // LED write / readback, read-during-write returns old value
    wr(16'hC000, 8'hA5);
    check("led_wr", led, 8'hA5);
    rd(16'hC000, "led_rd", 8'hA5);
    bus.address = 16'hC000;
    bus.out     = 8'h3C;
    bus.we      = 1'b1;
    tick();
    bus.we      = 1'b0;
    check("rw_old", bus.io_data, 8'hA5);
    check("rw_led", led, 8'h3C);
    rd(16'hC000, "led_rd2", 8'h3C);
    wr(16'hC001, 8'hFF);
    wr(16'hC003, 8'h00);
    rd(16'hC001, "key_ro", 8'h00);
    rd(16'hC003, "id_ro", 8'h65);

    // Clean press of key[2]: stable rises on the 6th edge, read shows it on the 7th
    bus.address = 16'hC001;
    key = 4'b1011;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("k2_lat%0d", k), bus.io_data, (k == 7) ? 8'h04 : 8'h00);
    end
    rd(16'hC001, "k2_key", 8'h04);
    rd(16'hC002, "k2_edge", 8'h04);

    // Bounce on key[0]: low 3, high 1, low; stable rises 6 edges after final fall
    bus.address = 16'hC001;
    key = 4'b1010;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check($sformatf("k0_bnc%0d", k), bus.io_data, (k == 11) ? 8'h05 : 8'h04);
      if (k == 3) key[0] = 1'b1;
      if (k == 4) key[0] = 1'b0;
    end
    rd(16'hC002, "k0_edge", 8'h05);

    // Clear all edges on the same edge key[1] becomes stable: set wins
    bus.address = 16'hC001;
    key = 4'b1000;
    for (int k = 1; k <= 5; k++) tick();
    wr(16'hC002, 8'hFF);
    rd(16'hC002, "clr_set", 8'h02);
    rd(16'hC001, "k1_key", 8'h07);

    // Release everything: no edge bit re-sets
    key = 4'hF;
    for (int k = 1; k <= 8; k++) tick();
    rd(16'hC001, "rel_key", 8'h00);
    rd(16'hC002, "rel_edge", 8'h02);

    // Async reset mid-count with key[3] held
    wr(16'hC000, 8'h5A);
    bus.address = 16'hC001;
    key = 4'b0111;
    for (int k = 1; k <= 3; k++) tick();
    check("pre_hit", {7'b0, bus.io_hit}, 8'h01);
    check("pre_led", led, 8'h5A);
    #2 reset_n = 1'b0;
    #1;
    check("ar_led", led, 8'h00);
    check("ar_hit", {7'b0, bus.io_hit}, 8'h00);
    check("ar_data", bus.io_data, 8'h00);
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("k3_lat%0d", k), bus.io_data, (k == 7) ? 8'h08 : 8'h00);
    end
    rd(16'hC002, "k3_edge", 8'h08);
    rd(16'hC000, "k3_led", 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
